multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Multi-cycle sequencer for the RV32 base datapath. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB, and drives the shared memory port, IR/PC write enables, ALU control and register-file write. It handles R-type, load, store and branch, and replaces the single-cycle opcode decode wherever the datapath shares one memory and one ALU across cycles.

## Interface
- No parameters; all encodings come from the shared package.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `run` in 1: start/continue enable. Sampled in IDLE and at the instruction boundary.
- `opcode` in 7: IR[6:0]. Valid from DECODE onward.
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory completion. Meaningful only while `mem_req`=1.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_sel` out 1: address source, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: latch instruction into IR and old PC.
- `pc_write` out 1: update PC.
- `pc_src` out 1: 0 = PC+4, 1 = branch target.
- `alu_src` out 1: 0 = rs2, 1 = immediate.
- `alu_op` out 2: 00 = add, 01 = branch compare, 10 = funct decode.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 1: writeback source, 1 = memory data.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Reset state is IDLE.
- Instruction class register `cls` (NONE/RTYPE/LOAD/STORE/BRANCH).
  - Loaded in DECODE from `opcode`: 0110011 = RTYPE, 0000011 = LOAD, 0100011 = STORE, 1100011 = BRANCH, anything else = NONE.
  - Cleared by reset.
  - Outputs in EXEC/MEM/WB depend only on `cls`, never on live `opcode`.
- IDLE: all outputs 0. If `run`=1, go to FETCH.
- FETCH:
  - Drives `mem_req`=1, `mem_sel`=0, `mem_we`=0.
  - While `mem_ready`=0: hold state and outputs.
  - On `mem_ready`=1, in the same cycle: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE (one cycle): load `cls`.
  - If NONE: `illegal`=1, then go to FETCH if `run`=1, else IDLE.
  - Otherwise go to EXEC.
- EXEC:
  - RTYPE: `alu_src`=0, `alu_op`=10, go to WB.
  - LOAD/STORE: `alu_src`=1, `alu_op`=00, go to MEM.
  - BRANCH: `alu_src`=0, `alu_op`=01, `retire`=1. If `zero`=1, also `pc_write`=1 and `pc_src`=1. Then go to FETCH if `run`=1, else IDLE.
- MEM:
  - Drives `mem_req`=1, `mem_sel`=1, `mem_we`=(`cls`==STORE), `alu_src`=1, `alu_op`=00.
  - Holds while `mem_ready`=0.
  - On `mem_ready`=1: STORE asserts `retire`=1 and goes to FETCH/IDLE (per `run`); LOAD goes to WB.
- WB:
  - `reg_write`=1, `mem_to_reg`=(`cls`==LOAD), `retire`=1.
  - Then go to FETCH if `run`=1, else IDLE.
- `run`=0 takes effect only at an instruction boundary (DECODE-illegal, EXEC-branch, MEM-store, WB) or in IDLE. It never aborts an access in progress.
- Outputs not named in a state are 0.
- `illegal` and `retire` are never asserted in the same cycle.

## Timing
- `rst_n` low: state = IDLE and `cls` = NONE asynchronously. All outputs read 0 during reset and in the first cycle after release.
- Reset mid-access: `mem_req` drops immediately and no write-enable pulse is emitted. After release the FSM restarts from IDLE.
- `mem_ready` may arrive in the same cycle as `mem_req` (zero wait).
- `mem_req`, `mem_sel` and `mem_we` are stable from request to completion.
- Instruction latency with zero-wait memory, counted FETCH to retire inclusive:
  - Branch: 3 cycles.
  - R-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- `ir_write`, `pc_write` (FETCH and branch), `illegal` and `retire` are Mealy pulses lasting exactly one cycle. All other outputs are functions of state and `cls` only.
- With `run` held high, the cycle after a retire or illegal pulse is FETCH. There are no bubbles.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - State enum (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5).
  - Class enum.
  - Opcode constants: OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALU op constants: ALU_ADD=00, ALU_BR=01, ALU_FUNCT=10.
- Sub-module `ctrl_opcode_class`: combinational opcode-to-class decoder, reusable by the pipelined core.
- Top level holds the state register, the `cls` register, next-state logic and output logic.

## Test plan
- Reset values: hold `rst_n`=0 with `run`=1 → every output 0 and `state`=0. After release, FETCH with `mem_req`=1 begins on the second cycle.
- R-type: `opcode`=0110011, `mem_ready`=1 → `ir_write`/`pc_write` in cycle 1, `alu_op`=10 in cycle 3, `reg_write`=1 and `retire`=1 in cycle 4, `mem_to_reg`=0.
- Load with 2 wait states in MEM: `opcode`=0000011 → `mem_sel`=1 and `mem_we`=0 held for 3 cycles, then WB with `mem_to_reg`=1. `retire` arrives 7 cycles after FETCH start.
- Store: `opcode`=0100011 → `mem_we`=1 in MEM, `retire` in the MEM completion cycle, `reg_write` never asserted.
- Branch: `opcode`=1100011 with `zero`=1 → EXEC asserts `pc_write`=1, `pc_src`=1, `retire`=1. With `zero`=0 → `pc_write`=0. Next state is FETCH in both cases.
- Illegal opcode 1111111 → `illegal` pulses in DECODE, no `mem_req`/`reg_write`/`retire`, return to FETCH. Separately: `rst_n` pulled low mid-MEM → immediate IDLE with all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer and its opcode decoder.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } cls_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode-to-class decoder; shared with the pipelined core's decode stage.
module ctrl_opcode_class
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       cls_o
);

  always_comb begin
    cls_o = CLS_NONE;
    case (opcode_i)
      OP_RTYPE:  cls_o = CLS_RTYPE;
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_BRANCH: cls_o = CLS_BRANCH;
      default:   cls_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory port and ALU.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       retire,
  output logic [2:0] state
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   dec_cls;

  ctrl_opcode_class u_dec (
    .opcode_i (opcode),
    .cls_o    (dec_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign state = state_q;

  // Outputs past DECODE key off the registered class so a changing IR bus cannot glitch them.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_NONE) begin
          illegal = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_RTYPE: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CLS_BRANCH: begin
            alu_op   = ALU_BR;
            retire   = 1'b1;
            pc_write = zero;
            pc_src   = zero;
            state_d  = run ? S_FETCH : S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        alu_src = 1'b1;
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LOAD);
        retire     = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed cycle-by-cycle check of the multi-cycle control sequencer.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n, run, zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_src;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, illegal, retire;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Output vector order: mem_req mem_we mem_sel ir_write pc_write pc_src alu_src alu_op[1:0]
  //                      reg_write mem_to_reg illegal retire
  localparam logic [12:0] MREQ = 13'h1000, MWE  = 13'h0800, MSEL = 13'h0400;
  localparam logic [12:0] IRW  = 13'h0200, PCW  = 13'h0100, PCS  = 13'h0080;
  localparam logic [12:0] ASRC = 13'h0040, AFN  = 13'h0020, ABR  = 13'h0010;
  localparam logic [12:0] RW   = 13'h0008, M2R  = 13'h0004, ILL  = 13'h0002, RET = 13'h0001;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;

  localparam logic [6:0] O_R = 7'b0110011, O_LD = 7'b0000011, O_ST = 7'b0100011;
  localparam logic [6:0] O_BR = 7'b1100011, O_BAD = 7'b1111111;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .retire     (retire),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {state, mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_src,
            alu_op, reg_write, mem_to_reg, illegal, retire};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st, input logic [12:0] outs);
    logic [15:0] o, e;
    o = obs();
    e = {st, outs};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Inputs are set just after a rising edge; sample on the falling edge, then advance.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] outs);
    @(negedge clk);
    chk(tag, st, outs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    @(posedge clk); #1;
    cyc("rst_hold0", ST_IDLE, 13'h0);
    cyc("rst_hold1", ST_IDLE, 13'h0);
    rst_n = 1'b1;
    cyc("rst_release", ST_IDLE, 13'h0);

    // R-type, zero-wait fetch
    opcode = O_R; mem_ready = 1'b1;
    cyc("r_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("r_decode", ST_DECODE, 13'h0);
    cyc("r_exec",   ST_EXEC,   AFN);
    cyc("r_wb",     ST_WB,     RW | RET);

    // Load with two MEM wait states; opcode bus changes mid-flight
    opcode = O_LD;
    cyc("ld_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("ld_decode", ST_DECODE, 13'h0);
    opcode = O_ST;
    cyc("ld_exec",   ST_EXEC,   ASRC);
    mem_ready = 1'b0;
    cyc("ld_mem_w1", ST_MEM,    MREQ | MSEL | ASRC);
    cyc("ld_mem_w2", ST_MEM,    MREQ | MSEL | ASRC);
    mem_ready = 1'b1;
    cyc("ld_mem_ok", ST_MEM,    MREQ | MSEL | ASRC);
    cyc("ld_wb",     ST_WB,     RW | M2R | RET);

    // Store with one FETCH wait state
    opcode = O_ST; mem_ready = 1'b0;
    cyc("st_fetch_w", ST_FETCH,  MREQ);
    mem_ready = 1'b1;
    cyc("st_fetch",   ST_FETCH,  MREQ | IRW | PCW);
    cyc("st_decode",  ST_DECODE, 13'h0);
    cyc("st_exec",    ST_EXEC,   ASRC);
    cyc("st_mem",     ST_MEM,    MREQ | MWE | MSEL | ASRC | RET);

    // Branch taken then not taken
    opcode = O_BR; zero = 1'b1;
    cyc("bt_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("bt_decode", ST_DECODE, 13'h0);
    cyc("bt_exec",   ST_EXEC,   ABR | PCW | PCS | RET);
    zero = 1'b0;
    cyc("bn_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("bn_decode", ST_DECODE, 13'h0);
    cyc("bn_exec",   ST_EXEC,   ABR | RET);

    // Illegal opcode returns straight to FETCH
    opcode = O_BAD;
    cyc("il_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("il_decode", ST_DECODE, ILL);

    // run drops mid-instruction: the R-type still completes, then IDLE
    opcode = O_R;
    cyc("rs_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("rs_decode", ST_DECODE, 13'h0);
    run = 1'b0;
    cyc("rs_exec",   ST_EXEC,   AFN);
    cyc("rs_wb",     ST_WB,     RW | RET);
    cyc("rs_idle0",  ST_IDLE,   13'h0);
    cyc("rs_idle1",  ST_IDLE,   13'h0);
    run = 1'b1;
    cyc("rs_idle2",  ST_IDLE,   13'h0);

    // Reset asserted mid-MEM drops everything immediately
    opcode = O_LD;
    cyc("mr_fetch",  ST_FETCH,  MREQ | IRW | PCW);
    cyc("mr_decode", ST_DECODE, 13'h0);
    cyc("mr_exec",   ST_EXEC,   ASRC);
    mem_ready = 1'b0;
    cyc("mr_mem",    ST_MEM,    MREQ | MSEL | ASRC);
    rst_n = 1'b0;
    #1;
    chk("mr_async_rst", ST_IDLE, 13'h0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    cyc("mr_rst_hold", ST_IDLE, 13'h0);
    rst_n = 1'b1;
    cyc("mr_release",  ST_IDLE, 13'h0);
    mem_ready = 1'b0;
    cyc("mr_restart",  ST_FETCH, MREQ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
